// File: rtl/arcade_input_ctrl_if.sv
// Joystick-side and core-side control signals of arcade_input_ctrl.
// master drives joystick/status inputs; slave is the conditioning block.
interface arcade_input_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_FIRE    = 1
);
  logic                            reset_req;
  logic                            vblank;
  logic                            shared_ctrl;
  logic                            autofire_en;
  logic [NUM_PLAYERS*16-1:0]       joy_in;
  logic [NUM_PLAYERS*4-1:0]        dir_out;
  logic [NUM_PLAYERS*NUM_FIRE-1:0] fire_out;
  logic                            start1;
  logic                            start2;
  logic                            coin_pulse;
  logic                            core_reset;

  modport master (
    output reset_req, vblank, shared_ctrl, autofire_en, joy_in,
    input  dir_out, fire_out, start1, start2, coin_pulse, core_reset
  );

  modport slave (
    input  reset_req, vblank, shared_ctrl, autofire_en, joy_in,
    output dir_out, fire_out, start1, start2, coin_pulse, core_reset
  );
endinterface

// File: rtl/arcade_input_ctrl.sv
// Joystick conditioning (SOCD, shared/independent slots), queued frame-timed coin
// pulses and stretched core reset. Optional autofire under ARCADE_AUTOFIRE_EN.
module arcade_input_ctrl #(
  parameter int NUM_PLAYERS     = 2,
  parameter int NUM_FIRE        = 1,
  parameter int COIN_FRAMES     = 3,
  parameter int COIN_QUEUE      = 4,
  parameter int RST_CYCLES      = 1024,
  parameter int AUTOFIRE_FRAMES = 4
) (
  input  logic               clk_sys,
  input  logic               reset,
  arcade_input_ctrl_if.slave io
);
  localparam int DW = NUM_PLAYERS * 4;
  localparam int FW = NUM_PLAYERS * NUM_FIRE;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [3:0]    COIN_LAST = 4'(COIN_FRAMES - 1);
  localparam logic [3:0]    QMAX      = 4'(COIN_QUEUE);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {C_IDLE, C_HIGH, C_GAP} coin_state_e;

  logic          vblank_q, tick;
  logic [DW-1:0] dir_d, dir_q;
  logic [FW-1:0] fire_raw, fire_d, fire_q;
  logic          start1_d, start1_q, start2_d, start2_q;
  logic          coin_any, coin_q, coin_edge;
  logic [3:0]    queue_d, queue_q, coin_cnt_d, coin_cnt_q;
  logic          enq, deq, coin_pulse_d, coin_pulse_q;
  coin_state_e   state_d, state_q;
  logic [RW-1:0] rst_cnt_d, rst_cnt_q;
  logic          core_reset_d, core_reset_q;

  assign tick      = io.vblank & ~vblank_q;
  assign coin_edge = coin_any & ~coin_q;

  always_comb begin
    logic [15:0] w;
    w        = '0;
    dir_d    = '0;
    fire_raw = '0;
    start1_d = 1'b0;
    start2_d = 1'b0;
    coin_any = 1'b0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      w = io.shared_ctrl ? io.joy_in[15:0] : io.joy_in[p*16 +: 16];
      // Opposing directions cancel each other out.
      dir_d[p*4 +: 4] = {w[3] & ~w[2], w[2] & ~w[3], w[1] & ~w[0], w[0] & ~w[1]};
      fire_raw[p*NUM_FIRE +: NUM_FIRE] = w[4 +: NUM_FIRE];
      start1_d = start1_d | io.joy_in[p*16 + 4 + NUM_FIRE];
      start2_d = start2_d | io.joy_in[p*16 + 5 + NUM_FIRE];
      coin_any = coin_any | io.joy_in[p*16 + 6 + NUM_FIRE];
    end
  end

`ifdef ARCADE_AUTOFIRE_EN
  logic [NUM_PLAYERS-1:0]   af_act_d, af_act_q, af_tog_d, af_tog_q;
  logic [NUM_PLAYERS*4-1:0] af_cnt_d, af_cnt_q;

  always_comb begin
    logic held;
    held     = 1'b0;
    af_act_d = af_act_q;
    af_tog_d = af_tog_q;
    af_cnt_d = af_cnt_q;
    fire_d   = fire_raw;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      held = io.autofire_en & fire_raw[p*NUM_FIRE];
      if (!held) begin
        af_act_d[p]       = 1'b0;
        af_tog_d[p]       = 1'b0;
        af_cnt_d[p*4 +: 4] = '0;
      end else if (!af_act_q[p]) begin
        af_act_d[p]       = 1'b1;
        af_tog_d[p]       = 1'b1;
        af_cnt_d[p*4 +: 4] = '0;
      end else if (tick) begin
        if (af_cnt_q[p*4 +: 4] == 4'(AUTOFIRE_FRAMES - 1)) begin
          af_cnt_d[p*4 +: 4] = '0;
          af_tog_d[p]       = ~af_tog_q[p];
        end else begin
          af_cnt_d[p*4 +: 4] = af_cnt_q[p*4 +: 4] + 4'd1;
        end
      end
      fire_d[p*NUM_FIRE] = held ? af_tog_d[p] : fire_raw[p*NUM_FIRE];
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      af_act_q <= '0;
      af_tog_q <= '0;
      af_cnt_q <= '0;
    end else begin
      af_act_q <= af_act_d;
      af_tog_q <= af_tog_d;
      af_cnt_q <= af_cnt_d;
    end
  end
`else
  always_comb fire_d = fire_raw;
`endif

  always_comb begin
    state_d    = state_q;
    coin_cnt_d = coin_cnt_q;
    deq        = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (queue_q != '0) begin
          state_d    = C_HIGH;
          coin_cnt_d = '0;
          deq        = 1'b1;
        end
      end
      C_HIGH, C_GAP: begin
        if (tick) begin
          if (coin_cnt_q == COIN_LAST) begin
            coin_cnt_d = '0;
            state_d    = (state_q == C_HIGH) ? C_GAP : C_IDLE;
          end else begin
            coin_cnt_d = coin_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = C_IDLE;
    endcase
    // A dequeue in the same cycle frees the slot, so a full queue still accepts the edge.
    enq = coin_edge & ((queue_q < QMAX) | deq);
    case ({enq, deq})
      2'b10:   queue_d = queue_q + 4'd1;
      2'b01:   queue_d = queue_q - 4'd1;
      default: queue_d = queue_q;
    endcase
    coin_pulse_d = (state_q == C_HIGH);
  end

  // Counts cycles elapsed since reset_req fell; zero after reset means the
  // hold window starts immediately on reset release.
  always_comb begin
    rst_cnt_d    = rst_cnt_q;
    core_reset_d = core_reset_q;
    if (io.reset_req) begin
      rst_cnt_d    = '0;
      core_reset_d = 1'b1;
    end else if (rst_cnt_q != RST_LAST) begin
      rst_cnt_d    = rst_cnt_q + 1'b1;
      core_reset_d = 1'b1;
    end else begin
      core_reset_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vblank_q     <= 1'b0;
      dir_q        <= '0;
      fire_q       <= '0;
      start1_q     <= 1'b0;
      start2_q     <= 1'b0;
      coin_q       <= 1'b0;
      queue_q      <= '0;
      coin_cnt_q   <= '0;
      state_q      <= C_IDLE;
      coin_pulse_q <= 1'b0;
      rst_cnt_q    <= '0;
      core_reset_q <= 1'b1;
    end else begin
      vblank_q     <= io.vblank;
      dir_q        <= dir_d;
      fire_q       <= fire_d;
      start1_q     <= start1_d;
      start2_q     <= start2_d;
      coin_q       <= coin_any;
      queue_q      <= queue_d;
      coin_cnt_q   <= coin_cnt_d;
      state_q      <= state_d;
      coin_pulse_q <= coin_pulse_d;
      rst_cnt_q    <= rst_cnt_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign io.dir_out    = dir_q;
  assign io.fire_out   = fire_q;
  assign io.start1     = start1_q;
  assign io.start2     = start2_q;
  assign io.coin_pulse = coin_pulse_q;
  assign io.core_reset = core_reset_q;
endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Self-checking bench for arcade_input_ctrl: vector table, random joystick words
// against a reference model, coin queue/pulse timing, reset stretching, autofire.
module tb_arcade_input_ctrl;
  localparam int NP   = 2;
  localparam int NF   = 1;
  localparam int CF   = 3;
  localparam int CQ   = 4;
  localparam int RSTC = 1024;
  localparam int AFF  = 4;
  localparam int F    = 16;
  localparam int CBIT = 6 + NF;
  localparam int HI_MIN = (CF - 1) * F + 1;
  localparam int HI_MAX = CF * F;
  localparam int LO_MIN = (CF - 1) * F + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  arcade_input_ctrl_if #(.NUM_PLAYERS(NP), .NUM_FIRE(NF)) bus ();

  arcade_input_ctrl #(
    .NUM_PLAYERS(NP), .NUM_FIRE(NF), .COIN_FRAMES(CF), .COIN_QUEUE(CQ),
    .RST_CYCLES(RSTC), .AUTOFIRE_FRAMES(AFF)
  ) dut (
    .clk_sys(clk),
    .reset  (rst),
    .io     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    bus.vblank = 1'b0;
    forever begin
      repeat (F - 4) @(negedge clk);
      bus.vblank = 1'b1;
      repeat (4) @(negedge clk);
      bus.vblank = 1'b0;
    end
  end

  initial begin
    #(10 * 20000);
    $display("FAIL watchdog: simulation exceeded cycle limit");
    $fatal(1);
  end

  int   mon_pulses = 0, mon_bad_hi = 0, mon_bad_lo = 0, mon_hl = 0, mon_ll = 1000, mon_last = 0;
  logic mon_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      mon_prev <= 1'b0;
      mon_hl   <= 0;
      mon_ll   <= 1000;
    end else begin
      if (bus.coin_pulse && !mon_prev) begin
        mon_pulses <= mon_pulses + 1;
        if (mon_ll < LO_MIN) mon_bad_lo <= mon_bad_lo + 1;
        mon_hl <= 1;
      end else if (bus.coin_pulse) begin
        mon_hl <= mon_hl + 1;
      end else if (mon_prev) begin
        if (mon_hl < HI_MIN || mon_hl > HI_MAX) begin
          mon_bad_hi <= mon_bad_hi + 1;
          mon_last   <= mon_hl;
        end
        mon_ll <= 1;
      end else if (mon_ll < 1000) begin
        mon_ll <= mon_ll + 1;
      end
      mon_prev <= bus.coin_pulse;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic sh, input logic [NP*16-1:0] j,
                                output logic [NP*4-1:0] ed, output logic [NP*NF-1:0] ef,
                                output logic es1, output logic es2);
    ed = '0; ef = '0; es1 = 1'b0; es2 = 1'b0;
    for (int p = 0; p < NP; p++) begin
      int src, h, v;
      logic [15:0] w;
      src = sh ? 0 : p;
      w   = 16'(j >> (src * 16));
      h   = int'(w[0]) - int'(w[1]);
      v   = int'(w[3]) - int'(w[2]);
      ed[p*4 + 0] = (h == 1);
      ed[p*4 + 1] = (h == -1);
      ed[p*4 + 2] = (v == -1);
      ed[p*4 + 3] = (v == 1);
      ef[p*NF +: NF] = w[4 +: NF];
      es1 = es1 | j[p*16 + 4 + NF];
      es2 = es2 | j[p*16 + 5 + NF];
    end
  endfunction

  task automatic coin_edge(input int unsigned wsel);
    @(negedge clk);
    bus.joy_in[wsel*16 + CBIT] = 1'b1;
    @(negedge clk);
    bus.joy_in[wsel*16 + CBIT] = 1'b0;
  endtask

  task automatic wait_coin_high(input string name);
    int n;
    n = 0;
    while (!bus.coin_pulse && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus.coin_pulse), 32'd1);
  endtask

  task automatic count_core_reset(input string name);
    int n;
    n = 0;
    while (bus.core_reset && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(n), 32'(RSTC));
  endtask

  typedef struct {
    logic        sh;
    logic [31:0] joy;
    logic [7:0]  dir;
    logic [1:0]  fire;
    logic        s1;
    logic        s2;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int s0, bh0, bl0, bad, trans;
    logic prev;
    logic [NP*16-1:0] jr;
    logic [15:0] mask;
    logic [NP*4-1:0] ed;
    logic [NP*NF-1:0] ef;
    logic es1, es2, sh;

    tbl[0] = '{1'b0, 32'h0000_0003, 8'h00, 2'b00, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'h0000_0009, 8'h09, 2'b00, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 32'h0000_0010, 8'h00, 2'b11, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_0010, 8'h00, 2'b01, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 32'h0020_0000, 8'h00, 2'b00, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 32'h0006_000C, 8'h00, 2'b00, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 32'h000A_0006, 8'hA6, 2'b00, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 32'h0000_0040, 8'h00, 2'b00, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 32'h0011_000F, 8'h10, 2'b10, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 32'h0000_0019, 8'h99, 2'b11, 1'b0, 1'b0};

    bus.reset_req   = 1'b0;
    bus.shared_ctrl = 1'b0;
    bus.autofire_en = 1'b0;
    bus.joy_in      = '0;
    repeat (3) @(negedge clk);
    chk("rst_dir",   32'(bus.dir_out), 32'h0);
    chk("rst_fire",  32'(bus.fire_out), 32'h0);
    chk("rst_start", 32'({bus.start1, bus.start2}), 32'h0);
    chk("rst_coin",  32'(bus.coin_pulse), 32'h0);
    chk("rst_core",  32'(bus.core_reset), 32'h1);

    rst = 1'b0;
    count_core_reset("core_reset_hold");

    @(negedge clk); bus.reset_req = 1'b1;
    @(negedge clk); bus.reset_req = 1'b0;
    repeat (500) @(posedge clk);
    #1 chk("core_reset_mid", 32'(bus.core_reset), 32'h1);
    @(negedge clk); bus.reset_req = 1'b1;
    @(negedge clk); bus.reset_req = 1'b0;
    count_core_reset("core_reset_restart");

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.shared_ctrl = tbl[i].sh;
      bus.joy_in      = tbl[i].joy;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_dir", i),   32'(bus.dir_out), 32'(tbl[i].dir));
      chk($sformatf("tbl%0d_fire", i),  32'(bus.fire_out), 32'(tbl[i].fire));
      chk($sformatf("tbl%0d_start", i), 32'({bus.start1, bus.start2}), 32'({tbl[i].s1, tbl[i].s2}));
    end

    @(negedge clk); bus.shared_ctrl = 1'b0; bus.joy_in = '0;
    @(negedge clk); bus.joy_in = 32'h0000_0009;
    #1 chk("lat_before_edge", 32'(bus.dir_out), 32'h00);
    @(posedge clk);
    #1 chk("lat_after_edge", 32'(bus.dir_out), 32'h09);

    mask = 16'hFFFF;
    mask[CBIT] = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      sh = 1'($urandom_range(0, 1));
      for (int p = 0; p < NP; p++) jr[p*16 +: 16] = 16'($urandom) & mask;
      bus.shared_ctrl = sh;
      bus.joy_in      = jr;
      model(sh, jr, ed, ef, es1, es2);
      @(posedge clk);
      #1;
      chk("rand_dir",   32'(bus.dir_out), 32'(ed));
      chk("rand_fire",  32'(bus.fire_out), 32'(ef));
      chk("rand_start", 32'({bus.start1, bus.start2}), 32'({es1, es2}));
    end
    @(negedge clk); bus.joy_in = '0; bus.shared_ctrl = 1'b0;
    repeat (4) @(negedge clk);

    s0 = mon_pulses; bh0 = mon_bad_hi; bl0 = mon_bad_lo;
    coin_edge(0); coin_edge(1); coin_edge(0);
    repeat (450) @(negedge clk);
    chk("coin3_count", 32'(mon_pulses - s0), 32'd3);
    chk("coin3_high_len", 32'(mon_bad_hi - bh0), 32'(0));
    chk("coin3_gap_len", 32'(mon_bad_lo - bl0), 32'(0));

    s0 = mon_pulses; bh0 = mon_bad_hi; bl0 = mon_bad_lo;
    coin_edge(1);
    wait_coin_high("coin_sat_start");
    for (int k = 0; k < 6; k++) coin_edge(k % NP);
    repeat (700) @(negedge clk);
    chk("coin_sat_count", 32'(mon_pulses - s0), 32'(1 + ((6 < CQ) ? 6 : CQ)));
    chk("coin_sat_high_len", 32'(mon_bad_hi - bh0), 32'(0));
    chk("coin_sat_gap_len", 32'(mon_bad_lo - bl0), 32'(0));
    if (mon_bad_hi != 0) $display("note: last bad high length %0d", mon_last);

    coin_edge(0); coin_edge(0); coin_edge(0);
    wait_coin_high("async_coin_start");
    @(negedge clk); bus.joy_in = 32'h0009_0009;
    @(negedge clk);
    chk("pre_async_dir", 32'(bus.dir_out), 32'h99);
    rst = 1'b1;
    #1;
    chk("async_coin", 32'(bus.coin_pulse), 32'h0);
    chk("async_core", 32'(bus.core_reset), 32'h1);
    chk("async_dir",  32'(bus.dir_out), 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    s0 = mon_pulses;
    repeat (400) @(negedge clk);
    chk("async_queue_cleared", 32'(mon_pulses - s0), 32'd0);
    chk("post_async_dir", 32'(bus.dir_out), 32'h99);

    @(negedge clk); bus.joy_in = '0; bus.autofire_en = 1'b1;
    @(negedge clk); bus.joy_in[4] = 1'b1;
    @(posedge clk);
    #1 chk("af_press", 32'(bus.fire_out[0]), 32'h1);
`ifdef ARCADE_AUTOFIRE_EN
    prev = bus.fire_out[0];
    trans = 0;
    for (int i = 0; i < 20 * F + F / 2; i++) begin
      @(negedge clk);
      if (bus.fire_out[0] != prev) begin
        trans++;
        prev = bus.fire_out[0];
      end
    end
    chk("af_toggles", 32'(trans), 32'd5);
`else
    bad = 0;
    for (int i = 0; i < 3 * F; i++) begin
      @(negedge clk);
      if (bus.fire_out[0] !== 1'b1) bad++;
    end
    chk("af_passthrough", 32'(bad), 32'd0);
`endif
    @(negedge clk); bus.joy_in[4] = 1'b0;
    @(posedge clk);
    #1 chk("af_release", 32'(bus.fire_out[0]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
